// File: rtl/mult_seq_chunked.sv
// Multi-cycle NxN multiplier, signed or unsigned per operation, accumulating one
// CHUNK x CHUNK digit product per cycle and skipping all-zero digits.
module mult_seq_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ND = WIDTH / CHUNK;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  // Lowest set bit of mask at or above 'from'; MSB of the result flags "found".
  function automatic logic [IW:0] first_from(input logic [ND-1:0] mask, input int from);
    logic [IW:0] r;
    r = '0;
    for (int k = ND - 1; k >= 0; k--) begin
      if (mask[k] && k >= from) r = {1'b1, IW'(k)};
    end
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [WIDTH-1:0] ma, mb;
  logic [ND-1:0]   amask, bmask;
  logic [IW-1:0]   i, j;
  logic            neg;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [ND-1:0]    a_mask, b_mask;
  logic [IW:0]      a_first, b_first, i_next, j_next, b_restart;
  logic             zero_op, last_pair;
  logic [CHUNK-1:0] dig_a, dig_b;
  logic [2*CHUNK-1:0] dprod;
  logic [PW-1:0]    term;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    a_mask = '0;
    b_mask = '0;
    for (int k = 0; k < ND; k++) begin
      a_mask[k] = |a_mag[k*CHUNK +: CHUNK];
      b_mask[k] = |b_mag[k*CHUNK +: CHUNK];
    end
    a_first = first_from(a_mask, 0);
    b_first = first_from(b_mask, 0);
    zero_op = !a_first[IW] || !b_first[IW];

    j_next    = first_from(bmask, int'(j) + 1);
    i_next    = first_from(amask, int'(i) + 1);
    b_restart = first_from(bmask, 0);
    last_pair = !j_next[IW] && !i_next[IW];

    dig_a = ma[int'(i)*CHUNK +: CHUNK];
    dig_b = mb[int'(j)*CHUNK +: CHUNK];
    dprod = dig_a * dig_b;
    term  = PW'(dprod) << (CHUNK * (int'(i) + int'(j)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_op ? FINISH : CALC;
      CALC:    if (last_pair) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma      <= '0;
      mb      <= '0;
      amask   <= '0;
      bmask   <= '0;
      i       <= '0;
      j       <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ma      <= a_mag;
            mb      <= b_mag;
            neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            amask   <= a_mask;
            bmask   <= b_mask;
            i       <= a_first[IW-1:0];
            j       <= b_first[IW-1:0];
            product <= '0;
          end
        end
        CALC: begin
          product <= product + term;
          // Walk j over nonzero b digits, then advance i and restart j.
          if (j_next[IW]) begin
            j <= j_next[IW-1:0];
          end else if (i_next[IW]) begin
            i <= i_next[IW-1:0];
            j <= b_restart[IW-1:0];
          end
        end
        FINISH: begin
          if (neg) product <= -product;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_chunked.sv
// Directed and random checks of mult_seq_chunked (WIDTH=32, CHUNK=16) using an
// expected-result queue filled at accept time and drained when done rises.
module tb_mult_seq_chunked;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  mult_seq_chunked #(.WIDTH(32), .CHUNK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my;
    int nx, ny;
    mx = (sgn && x[31]) ? -x : x;
    my = (sgn && y[31]) ? -y : y;
    nx = int'(mx[15:0] != 0) + int'(mx[31:16] != 0);
    ny = int'(my[15:0] != 0) + int'(my[31:16] != 0);
    if (nx == 0 || ny == 0) return 1;
    return nx * ny + 1;
  endfunction

  // Drive a request in the half-cycle before edge E0; returns at E0+1.
  task automatic launch(input string tag, input bit sgn, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [63:0] exp, input int lat);
    @(negedge clk);
    start = 1'b1;
    is_signed = sgn;
    a = aa;
    b = bb;
    sb_q.push_back('{exp, lat, tag});
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
  endtask

  // Counts edges after E0 until done; optionally scrambles inputs while busy.
  task automatic wait_done(input bit junk, input bit hold);
    exp_t e;
    int n;
    n = 0;
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (junk && !done) begin
        a = $urandom;
        b = $urandom;
        is_signed = ~is_signed;
        start = (n < 4);
      end
    end
    start = 1'b0;
    check({e.tag, " done seen"}, 64'(done), 64'd1);
    check({e.tag, " latency"}, 64'(n), 64'(e.lat));
    check({e.tag, " product"}, product, e.prod);
    check({e.tag, " busy low at done"}, 64'(busy), 64'd0);
    if (hold) begin
      @(posedge clk);
      #1;
      check({e.tag, " done one cycle"}, 64'(done), 64'd0);
      check({e.tag, " product held"}, product, e.prod);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    int seen;

    reset = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    launch("u ffff*ffff", 1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000_FFFE0001, 2);
    wait_done(1'b0, 1'b1);
    launch("u 1ffff*ffff", 1'b0, 32'h0001FFFF, 32'h0000FFFF, 64'h00000001_FFFD0001, 3);
    wait_done(1'b0, 1'b1);
    launch("u ffff*1ffff", 1'b0, 32'h0000FFFF, 32'h0001FFFF, 64'h00000001_FFFD0001, 3);
    wait_done(1'b0, 1'b1);

    launch("u 1ffff*1ffff junk", 1'b0, 32'h0001FFFF, 32'h0001FFFF, 64'h00000003_FFFC0001, 5);
    wait_done(1'b1, 1'b1);

    launch("s min*min", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 2);
    wait_done(1'b0, 1'b1);
    launch("u min*min", 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 2);
    wait_done(1'b0, 1'b1);

    launch("s zero", 1'b1, 32'h00000000, 32'h12345678, 64'd0, 1);
    wait_done(1'b0, 1'b1);
    launch("u zero", 1'b0, 32'h00000000, 32'h12345678, 64'd0, 1);
    wait_done(1'b0, 1'b1);

    // Back-to-back: start held in the done cycle of the first job.
    launch("b2b first", 1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000_FFFE0001, 2);
    wait_done(1'b0, 1'b0);
    start = 1'b1;
    is_signed = 1'b1;
    a = 32'hFFFFFFFF;
    b = 32'h00000003;
    sb_q.push_back('{64'hFFFFFFFF_FFFFFFFD, 2, "s -1*3 b2b"});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b done dropped", 64'(done), 64'd0);
    check("b2b product cleared", product, 64'd0);
    check("b2b busy", 64'(busy), 64'd1);
    wait_done(1'b0, 1'b1);

    // Asynchronous reset mid-CALC abandons the job silently.
    launch("rst victim", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset product", product, 64'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("no done after reset", 64'(seen), 64'd0);
    launch("after reset", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5);
    wait_done(1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) ra[31:16] = '0;
      if ($urandom_range(0, 2) == 0) rb[15:0] = '0;
      rs = 1'($urandom_range(0, 1));
      launch($sformatf("rand %0d", k), rs, ra, rb, ref_mul(rs, ra, rb), ref_lat(rs, ra, rb));
      wait_done(1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
